cpu_clock_ctrl: RTL and testbench
=================================

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  - DIV_FAST, 1, terminal count in fast run mode.
  - DIV_SLOW, 25000000, terminal count in slow run mode.
  - CNT_W, 32, width of the divider counter and of tick_count.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  - clk, in, 1, single system clock; all state updates on rising edge.
  - reset, in, 1, asynchronous, active-low reset.
  - run_sw, in, 1, level; 1 requests continuous run.
  - fast_sel, in, 1, level; 1 selects DIV_FAST, 0 selects DIV_SLOW.
  - step_btn, in, 1, raw asynchronous single-step button.
  - halt, in, 1, synchronous halt request from the CPU.
  - resume, in, 1, synchronous pulse; releases HALTED.
  - cpu_tick, out, 1, registered one-cycle clock-enable for the CPU datapath.
  - clk_led, out, 1, toggles on every cpu_tick.
  - state, out, 2, current FSM state encoding.
  - tick_count, out, CNT_W, number of ticks issued.

Function
REQ-003 FSM states SHALL be IDLE=2'b00, RUN=2'b01 and HALTED=2'b10; 2'b11 SHALL be unreachable and SHALL decode to IDLE on the next edge.
REQ-004 FSM transitions SHALL be evaluated in this priority order:
  - any state with halt=1 -> HALTED;
  - IDLE with run_sw=1 -> RUN;
  - RUN with run_sw=0 -> IDLE;
  - HALTED with resume=1 and halt=0 -> RUN if run_sw=1, else IDLE.
REQ-005 Active divisor div SHALL equal DIV_FAST when fast_sel=1 and DIV_SLOW otherwise, sampled every cycle.
REQ-006 In RUN, the divider counter SHALL increment each cycle; when counter==div, the counter SHALL return to 0 and cpu_tick SHALL be 1 in the following cycle, giving a tick period of div+1 cycles.
REQ-007 If div changes so that counter>div, the counter SHALL clear to 0 with no tick; it SHALL never wrap through 2^CNT_W.
REQ-008 The divider counter SHALL be held at 0 in IDLE and HALTED, and SHALL be cleared on any transition out of RUN.
REQ-009 step_btn SHALL pass through a two-flop synchronizer followed by a rising-edge detector (sync2 & ~prev).
REQ-010 Step edges SHALL be honoured only in IDLE: one detected edge SHALL produce exactly one cpu_tick in the next cycle, i.e. cpu_tick is high 3 rising edges after step_btn is first sampled high. Step edges in RUN and HALTED SHALL be discarded, not queued.
REQ-011 A held-high step_btn SHALL produce only one tick.
REQ-012 halt SHALL take priority over a coincident terminal count or step edge: no tick is issued in that case.
REQ-013 halt and resume asserted together SHALL keep the block in HALTED.
REQ-014 cpu_tick SHALL never be high on two consecutive cycles; it SHALL be high for exactly one cycle per tick.
REQ-015 tick_count SHALL increment by 1 on every cycle cpu_tick=1 and SHALL wrap from all-ones to 0.
REQ-016 clk_led SHALL toggle on every cycle cpu_tick=1.

Reset
REQ-017 reset=0 SHALL asynchronously force all of the following, independent of clk: state=IDLE, divider counter=0, cpu_tick=0, clk_led=0, tick_count=0, synchronizer and edge registers=0.
REQ-018 After reset deasserts, the first transition SHALL occur on the first rising clk edge, with no spurious tick even if step_btn is already high.
REQ-019 reset asserted mid-count in RUN SHALL discard the partial count; no tick SHALL issue afterwards until a full div+1 period has elapsed in RUN.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (stimulus -> required response):
  - Fast run: DIV_FAST=1, run_sw=1, fast_sel=1 for 20 cycles -> cpu_tick on every 2nd cycle, tick_count=10 within ±1, clk_led toggling.
  - Divisor shrink: DIV_SLOW=9, fast_sel=0, counter=7, then fast_sel=1 with DIV_FAST=3 -> counter clears, no tick, next tick after 4 cycles.
  - Step: IDLE, step_btn held high 10 cycles -> exactly one tick on the 3rd edge. step_btn pulsed in RUN -> no extra tick.
  - Halt collision: halt asserted on the counter==div cycle -> no tick, state=2'b10. resume with halt=1 -> still 2'b10. resume alone with run_sw=1 -> RUN.
  - Wrap: tick_count forced to 0xFFFFFFFF, one tick -> tick_count=0.
  - Async reset: reset=0 between clk edges mid-run -> all outputs 0 immediately. step_btn=1 at release -> no tick.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: divided free run, single-step from a raw button, halt/resume.
// Latency: cpu_tick is registered, one cycle after terminal count or detected step edge; no backpressure.
module cpu_clock_ctrl #(
    parameter int unsigned DIV_FAST = 1,
    parameter int unsigned DIV_SLOW = 25000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             fast_sel,
    input  logic             step_btn,
    input  logic             halt,
    input  logic             resume,
    output logic             cpu_tick,
    output logic             clk_led,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10,
        BAD    = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] DIV_FAST_C = CNT_W'(DIV_FAST);
    localparam logic [CNT_W-1:0] DIV_SLOW_C = CNT_W'(DIV_SLOW);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] tick_count_q;
    logic [CNT_W-1:0] div;
    logic             tick_q, tick_d;
    logic             led_q;
    logic             sync1_q, sync2_q, prev_q;
    logic [2:0]       warm_q;
    logic             step_edge;

    assign div = fast_sel ? DIV_FAST_C : DIV_SLOW_C;

    // warm_q masks the edge detector until the synchronizer holds real samples,
    // so a button already held at reset release cannot fire a step.
    assign step_edge = sync2_q & ~prev_q & warm_q[2];

    always_comb begin
        state_d = state_q;
        if (halt) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                IDLE:    if (run_sw)  state_d = RUN;
                RUN:     if (!run_sw) state_d = IDLE;
                HALTED:  if (resume)  state_d = run_sw ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        div_cnt_d = '0;
        tick_d    = 1'b0;
        if (state_q == RUN && state_d == RUN) begin
            if (div_cnt_q == div) begin
                tick_d = 1'b1;
            end else if (div_cnt_q < div) begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
        if (state_q == IDLE && !halt && step_edge) begin
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            tick_q       <= 1'b0;
            led_q        <= 1'b0;
            tick_count_q <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            warm_q       <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            if (tick_d) begin
                led_q        <= ~led_q;
                tick_count_q <= tick_count_q + CNT_W'(1);
            end
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            warm_q  <= {warm_q[1:0], 1'b1};
        end
    end

    assign cpu_tick   = tick_q;
    assign clk_led    = led_q;
    assign state      = state_q;
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_cpu_clock_ctrl;

    localparam int DF = 1;
    localparam int DS = 9;
    localparam int W  = 8;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         run_sw   = 1'b0;
    logic         fast_sel = 1'b0;
    logic         step_btn = 1'b0;
    logic         halt     = 1'b0;
    logic         resume   = 1'b0;
    logic         cpu_tick;
    logic         clk_led;
    logic [1:0]   state;
    logic [W-1:0] tick_count;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    cpu_clock_ctrl #(
        .DIV_FAST (DF),
        .DIV_SLOW (DS),
        .CNT_W    (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_sw     (run_sw),
        .fast_sel   (fast_sel),
        .step_btn   (step_btn),
        .halt       (halt),
        .resume     (resume),
        .cpu_tick   (cpu_tick),
        .clk_led    (clk_led),
        .state      (state),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Behavioural model: m_phase counts RUN cycles spent in the current tick period;
    // m_hist keeps every step_btn sample taken since reset.
    int m_state = S_IDLE;
    int m_phase = 0;
    int m_count = 0;
    bit m_tick  = 1'b0;
    bit m_led   = 1'b0;
    bit m_hist[$];
    int m_dv, m_nxt, m_sz;
    bit m_stp, m_t;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_state = S_IDLE;
            m_phase = 0;
            m_count = 0;
            m_tick  = 1'b0;
            m_led   = 1'b0;
            m_hist.delete();
        end else begin
            m_dv  = fast_sel ? DF : DS;
            m_nxt = m_state;
            if (halt)                              m_nxt = S_HALT;
            else if (m_state == S_IDLE && run_sw)  m_nxt = S_RUN;
            else if (m_state == S_RUN && !run_sw)  m_nxt = S_IDLE;
            else if (m_state == S_HALT && resume)  m_nxt = run_sw ? S_RUN : S_IDLE;
            m_t = 1'b0;
            if (m_state == S_RUN && m_nxt == S_RUN) begin
                m_phase++;
                if (m_phase == m_dv + 1) begin
                    m_t     = 1'b1;
                    m_phase = 0;
                end else if (m_phase > m_dv + 1) begin
                    m_phase = 0;
                end
            end else begin
                m_phase = 0;
            end
            // A step fires when the sample two edges back is high and the one before it low.
            m_sz  = m_hist.size();
            m_stp = (m_sz >= 3) && m_hist[m_sz-2] && !m_hist[m_sz-3];
            if (m_state == S_IDLE && !halt && m_stp) m_t = 1'b1;
            m_hist.push_back(step_btn);
            if (m_t) begin
                m_count = (m_count + 1) % (1 << W);
                m_led   = !m_led;
            end
            m_tick  = m_t;
            m_state = m_nxt;
        end
    end

    bit prev_tick = 1'b0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cpu_tick",   int'(cpu_tick),   int'(m_tick));
            chk("clk_led",    int'(clk_led),    int'(m_led));
            chk("state",      int'(state),      m_state);
            chk("tick_count", int'(tick_count), m_count);
            chk("no_back_to_back_tick", int'(cpu_tick && prev_tick), 0);
            prev_tick = cpu_tick;
        end
    end

    int base;
    int g;

    initial begin
        cyc(3);
        chk("reset_state",      int'(state),      0);
        chk("reset_cpu_tick",   int'(cpu_tick),   0);
        chk("reset_clk_led",    int'(clk_led),    0);
        chk("reset_tick_count", int'(tick_count), 0);
        reset  = 1'b1;
        chk_en = 1'b1;
        cyc(2);

        // Fast run for 20 cycles: a tick every 2nd cycle.
        run_sw = 1'b1; fast_sel = 1'b1;
        cyc(20);
        chk("fast_run_count_9_to_11", int'(tick_count >= 9 && tick_count <= 11), 1);

        // Divisor shrink: counter reaches 7 with div=9, then div drops to 1.
        run_sw = 1'b0;
        cyc(2);
        chk("shrink_start_idle", int'(state), S_IDLE);
        fast_sel = 1'b0; run_sw = 1'b1;
        base = int'(tick_count);
        cyc(8);
        fast_sel = 1'b1;
        cyc(1);
        chk("shrink_clear_no_tick", int'(cpu_tick), 0);
        cyc(1);
        chk("shrink_gap_no_tick", int'(cpu_tick), 0);
        cyc(1);
        chk("shrink_next_tick", int'(cpu_tick), 1);
        chk("shrink_count", int'(tick_count), (base + 1) % (1 << W));

        // Step held high in IDLE: single tick on the 3rd edge.
        run_sw = 1'b0;
        cyc(3);
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            chk($sformatf("step_hold_edge%0d", i), int'(cpu_tick), (i == 3) ? 1 : 0);
        end
        step_btn = 1'b0;
        cyc(3);

        // Step pulse during RUN is discarded and not replayed in IDLE.
        fast_sel = 1'b0; run_sw = 1'b1;
        cyc(1);
        base = int'(tick_count);
        step_btn = 1'b1;
        cyc(2);
        step_btn = 1'b0;
        cyc(6);
        chk("step_in_run_ignored", int'(tick_count), base);
        run_sw = 1'b0;
        cyc(4);
        chk("step_not_queued", int'(tick_count), base);
        chk("step_back_idle", int'(state), S_IDLE);

        // Halt on the terminal-count cycle.
        fast_sel = 1'b1; run_sw = 1'b1;
        cyc(2);
        base = int'(tick_count);
        halt = 1'b1;
        cyc(1);
        chk("halt_no_tick", int'(cpu_tick), 0);
        chk("halt_state", int'(state), S_HALT);
        chk("halt_count", int'(tick_count), base);
        resume = 1'b1;
        cyc(1);
        chk("halt_resume_together", int'(state), S_HALT);
        halt = 1'b0;
        cyc(1);
        chk("resume_to_run", int'(state), S_RUN);
        resume = 1'b0;

        // tick_count wrap from all-ones.
        g = 0;
        while (tick_count != {W{1'b1}} && g < 2000) begin
            cyc(1);
            g++;
        end
        chk("wrap_reached_all_ones", int'(tick_count), (1 << W) - 1);
        cyc(1);
        g = 0;
        while (!cpu_tick && g < 10) begin
            cyc(1);
            g++;
        end
        chk("wrap_tick_seen", int'(cpu_tick), 1);
        chk("wrap_to_zero", int'(tick_count), 0);

        // Asynchronous reset between edges, step_btn high through release.
        cyc(3);
        #1 reset = 1'b0; step_btn = 1'b1;
        #1;
        chk("async_rst_cpu_tick",   int'(cpu_tick),   0);
        chk("async_rst_clk_led",    int'(clk_led),    0);
        chk("async_rst_state",      int'(state),      0);
        chk("async_rst_tick_count", int'(tick_count), 0);
        run_sw = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            chk($sformatf("rst_release_no_tick%0d", i), int'(cpu_tick), 0);
        end
        step_btn = 1'b0;
        cyc(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 29) == 0) fast_sel = ~fast_sel;
            if ($urandom_range(0, 5) == 0)  step_btn = ~step_btn;
            halt   = ($urandom_range(0, 24) == 0);
            resume = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 1'b0;
                cyc(1);
                reset = 1'b1;
            end else begin
                cyc(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
